// File: rtl/rv_decode_stage.sv
// RV32I/RV32E decode stage: one-slot registered execute bundle between fetch and execute.
// Defining RV_DEC_BYPASS_EN forwards the writeback port onto the operand read data.
module rv_decode_stage #(
   parameter int NREGS = 32,
   parameter int OPW   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [31:0]     in_pc,
   input  logic            flush,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [31:0]     rs1_data,
   input  logic [31:0]     rs2_data,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [31:0]     wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OPW-1:0]  out_alu_op,
   output logic [31:0]     out_alu_x,
   output logic [31:0]     out_alu_y,
   output logic [31:0]     out_rs2,
   output logic [31:0]     out_imm,
   output logic [31:0]     out_target,
   output logic [31:0]     out_pc,
   output logic [4:0]      out_rd,
   output logic            out_wb_en,
   output logic            out_mem_rd,
   output logic            out_mem_wr,
   output logic            out_branch,
   output logic            out_jump,
   output logic            out_illegal,
   output logic [2:0]      out_mem_size
);

   localparam logic [OPW-1:0] ALU_ADD  = OPW'(0);
   localparam logic [OPW-1:0] ALU_SUB  = OPW'(1);
   localparam logic [OPW-1:0] ALU_SLL  = OPW'(2);
   localparam logic [OPW-1:0] ALU_SLT  = OPW'(3);
   localparam logic [OPW-1:0] ALU_SLTU = OPW'(4);
   localparam logic [OPW-1:0] ALU_XOR  = OPW'(5);
   localparam logic [OPW-1:0] ALU_SRL  = OPW'(6);
   localparam logic [OPW-1:0] ALU_SRA  = OPW'(7);
   localparam logic [OPW-1:0] ALU_OR   = OPW'(8);
   localparam logic [OPW-1:0] ALU_AND  = OPW'(9);
   localparam logic [OPW-1:0] ALU_EQ   = OPW'(10);
   localparam logic [OPW-1:0] ALU_NE   = OPW'(11);
   localparam logic [OPW-1:0] ALU_GE   = OPW'(12);
   localparam logic [OPW-1:0] ALU_GEU  = OPW'(13);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [5:0] NREGS_L = 6'(NREGS);

   typedef struct packed {
      logic [OPW-1:0] alu_op;
      logic [31:0]    alu_x;
      logic [31:0]    alu_y;
      logic [31:0]    rs2;
      logic [31:0]    imm;
      logic [31:0]    target;
      logic [31:0]    pc;
      logic [4:0]     rd;
      logic           wb_en;
      logic           mem_rd;
      logic           mem_wr;
      logic           branch;
      logic           jump;
      logic           illegal;
      logic [2:0]     mem_size;
   } bundle_t;

   bundle_t     dec, bundle_d, bundle_q;
   logic        out_valid_d, out_valid_q;
   logic        accept;
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd_f;
   logic        use_rs1, use_rs2, use_rd, bad;

   function automatic logic [OPW-1:0] alu_sel(input logic [2:0] f3, input logic alt);
      logic [OPW-1:0] op;
      case (f3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic reg_oob(input logic [4:0] idx);
      return {1'b0, idx} >= NREGS_L;
   endfunction

   assign opcode   = in_instr[6:0];
   assign rd_f     = in_instr[11:7];
   assign funct3   = in_instr[14:12];
   assign funct7   = in_instr[31:25];
   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

`ifdef RV_DEC_BYPASS_EN
   assign rs1_val = (wb_en && wb_rd != 5'd0 && wb_rd == rs1_addr) ? wb_data : rs1_data;
   assign rs2_val = (wb_en && wb_rd != 5'd0 && wb_rd == rs2_addr) ? wb_data : rs2_data;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_en, wb_rd, wb_data};
   assign rs1_val   = rs1_data;
   assign rs2_val   = rs2_data;
`endif

   always_comb begin
      dec        = '0;
      dec.pc     = in_pc;
      dec.rs2    = rs2_val;
      dec.alu_op = ALU_ADD;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      use_rd     = 1'b0;
      bad        = 1'b0;
      case (opcode)
         OPC_OP: begin
            {use_rs1, use_rs2, use_rd} = 3'b111;
            dec.alu_x  = rs1_val;
            dec.alu_y  = rs2_val;
            dec.wb_en  = 1'b1;
            dec.alu_op = alu_sel(funct3, funct7[5]);
            bad = !(funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)));
         end
         OPC_OPIMM: begin
            {use_rs1, use_rd} = 2'b11;
            dec.imm    = imm_i;
            dec.alu_x  = rs1_val;
            dec.alu_y  = imm_i;
            dec.wb_en  = 1'b1;
            dec.alu_op = alu_sel(funct3, funct3 == 3'd5 && in_instr[30]);
            if (funct3 == 3'd1) bad = funct7 != 7'b0000000;
            if (funct3 == 3'd5) bad = funct7 != 7'b0000000 && funct7 != 7'b0100000;
         end
         OPC_LOAD: begin
            {use_rs1, use_rd} = 2'b11;
            dec.imm      = imm_i;
            dec.alu_x    = rs1_val;
            dec.alu_y    = imm_i;
            dec.mem_rd   = 1'b1;
            dec.wb_en    = 1'b1;
            dec.mem_size = funct3;
            bad = funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7;
         end
         OPC_STORE: begin
            {use_rs1, use_rs2} = 2'b11;
            dec.imm      = imm_s;
            dec.alu_x    = rs1_val;
            dec.alu_y    = imm_s;
            dec.mem_wr   = 1'b1;
            dec.mem_size = funct3;
            bad = funct3 > 3'd2;
         end
         OPC_BRANCH: begin
            {use_rs1, use_rs2} = 2'b11;
            dec.imm    = imm_b;
            dec.alu_x  = rs1_val;
            dec.alu_y  = rs2_val;
            dec.branch = 1'b1;
            dec.target = in_pc + imm_b;
            case (funct3)
               3'd0:    dec.alu_op = ALU_EQ;
               3'd1:    dec.alu_op = ALU_NE;
               3'd4:    dec.alu_op = ALU_SLT;
               3'd5:    dec.alu_op = ALU_GE;
               3'd6:    dec.alu_op = ALU_SLTU;
               3'd7:    dec.alu_op = ALU_GEU;
               default: bad = 1'b1;
            endcase
         end
         OPC_JAL: begin
            use_rd     = 1'b1;
            dec.imm    = imm_j;
            dec.alu_x  = in_pc;
            dec.alu_y  = 32'd4;
            dec.wb_en  = 1'b1;
            dec.jump   = 1'b1;
            dec.target = in_pc + imm_j;
         end
         OPC_JALR: begin
            {use_rs1, use_rd} = 2'b11;
            dec.imm    = imm_i;
            dec.alu_x  = in_pc;
            dec.alu_y  = 32'd4;
            dec.wb_en  = 1'b1;
            dec.jump   = 1'b1;
            dec.target = (rs1_val + imm_i) & 32'hFFFF_FFFE;
            bad = funct3 != 3'd0;
         end
         OPC_LUI: begin
            use_rd    = 1'b1;
            dec.imm   = imm_u;
            dec.alu_y = imm_u;
            dec.wb_en = 1'b1;
         end
         OPC_AUIPC: begin
            use_rd    = 1'b1;
            dec.imm   = imm_u;
            dec.alu_x = in_pc;
            dec.alu_y = imm_u;
            dec.wb_en = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      dec.rd = use_rd ? rd_f : 5'd0;
      if ((use_rs1 && reg_oob(rs1_addr)) || (use_rs2 && reg_oob(rs2_addr)) ||
          (use_rd && reg_oob(rd_f)))
         bad = 1'b1;
      if (dec.rd == 5'd0) dec.wb_en = 1'b0;
      // Illegal bundles still flow so execute can raise the trap in order.
      if (bad) begin
         dec.illegal = 1'b1;
         dec.wb_en   = 1'b0;
         dec.mem_rd  = 1'b0;
         dec.mem_wr  = 1'b0;
         dec.branch  = 1'b0;
         dec.jump    = 1'b0;
      end
   end

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      out_valid_d = out_valid_q;
      bundle_d    = bundle_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         bundle_d    = dec;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         bundle_q    <= bundle_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_alu_op   = bundle_q.alu_op;
   assign out_alu_x    = bundle_q.alu_x;
   assign out_alu_y    = bundle_q.alu_y;
   assign out_rs2      = bundle_q.rs2;
   assign out_imm      = bundle_q.imm;
   assign out_target   = bundle_q.target;
   assign out_pc       = bundle_q.pc;
   assign out_rd       = bundle_q.rd;
   assign out_wb_en    = bundle_q.wb_en;
   assign out_mem_rd   = bundle_q.mem_rd;
   assign out_mem_wr   = bundle_q.mem_wr;
   assign out_branch   = bundle_q.branch;
   assign out_jump     = bundle_q.jump;
   assign out_illegal  = bundle_q.illegal;
   assign out_mem_size = bundle_q.mem_size;

endmodule
